// File: rtl/icache_refill_ctrl.sv
// Icache miss refill: forwards line-aligned miss addresses to memory (1-cycle latency) and assembles
// in-order beats into lines returned with MSHR ids in request order; every channel is valid/ready.

// Small generic FIFO with occupancy count; no overflow/underflow protection, caller gates push/pop.
module icache_refill_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]           mem_q [DEPTH];
  logic [W-1:0]           mem_d [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [$clog2(DEPTH):0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;
endmodule

module icache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   downstream_txreq_vld,
  output logic                   downstream_txreq_rdy,
  input  logic [ADDR_W-1:0]      downstream_txreq_pld,
  input  logic [ID_W-1:0]        downstream_txreq_entry_id,
  output logic                   downstream_rxdat_vld,
  input  logic                   downstream_rxdat_rdy,
  output logic [LINE_W-1:0]      downstream_rxdat_pld,
  output logic [ID_W-1:0]        downstream_rxdat_entry_id,
  output logic                   mem_req_vld,
  input  logic                   mem_req_rdy,
  output logic [ADDR_W-1:0]      mem_req_addr,
  input  logic                   mem_rsp_vld,
  output logic                   mem_rsp_rdy,
  input  logic [BEAT_W-1:0]      mem_rsp_data,
  output logic [$clog2(DEPTH):0] outstanding_cnt,
  output logic                   err_unexp_rsp
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [BCW-1:0]    LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  typedef enum logic {REQ_IDLE, REQ_PEND} req_state_e;
  typedef enum logic {RSP_FILL, RSP_HOLD} rsp_state_e;

  req_state_e        req_state_q, req_state_d;
  rsp_state_e        rsp_state_q, rsp_state_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ID_W-1:0]   rx_id_q, rx_id_d;
  logic              err_q, err_d;

  logic              txreq_hs, mem_req_hs, rsp_hs, rxdat_hs, rsp_drop, fifo_pop;
  logic [ID_W-1:0]   fifo_head;
  logic [CNT_W-1:0]  fifo_cnt;

  assign downstream_txreq_rdy = (req_state_q == REQ_IDLE) && (fifo_cnt < DEPTH_CNT);
  assign mem_req_vld          = (req_state_q == REQ_PEND);
  assign mem_rsp_rdy          = (rsp_state_q == RSP_FILL);
  assign downstream_rxdat_vld = (rsp_state_q == RSP_HOLD);

  assign txreq_hs   = downstream_txreq_vld && downstream_txreq_rdy;
  assign mem_req_hs = mem_req_vld && mem_req_rdy;
  assign rsp_hs     = mem_rsp_vld && mem_rsp_rdy;
  assign rxdat_hs   = downstream_rxdat_vld && downstream_rxdat_rdy;
  // A beat with no id waiting and no line in progress has no owner: drop it.
  assign rsp_drop   = rsp_hs && (fifo_cnt == '0) && (beat_cnt_q == '0);
  assign fifo_pop   = rsp_hs && !rsp_drop && (beat_cnt_q == LAST_BEAT);

  icache_refill_fifo #(.W(ID_W), .DEPTH(DEPTH)) u_id_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (txreq_hs),
    .push_dat (downstream_txreq_entry_id),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_cnt)
  );

  always_comb begin
    req_state_d    = req_state_q;
    mem_req_addr_d = mem_req_addr_q;
    case (req_state_q)
      REQ_IDLE: if (txreq_hs) begin
        req_state_d    = REQ_PEND;
        mem_req_addr_d = downstream_txreq_pld & LINE_MASK;
      end
      REQ_PEND: if (mem_req_hs) req_state_d = REQ_IDLE;
      default:  req_state_d = REQ_IDLE;
    endcase
  end

  always_comb begin
    rsp_state_d = rsp_state_q;
    beat_cnt_d  = beat_cnt_q;
    line_d      = line_q;
    rx_id_d     = rx_id_q;
    err_d       = err_q | rsp_drop;
    case (rsp_state_q)
      RSP_FILL: if (rsp_hs && !rsp_drop) begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat_cnt_q == BCW'(b)) line_d[b*BEAT_W +: BEAT_W] = mem_rsp_data;
        end
        if (beat_cnt_q == LAST_BEAT) begin
          beat_cnt_d  = '0;
          rx_id_d     = fifo_head;
          rsp_state_d = RSP_HOLD;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      RSP_HOLD: if (rxdat_hs) rsp_state_d = RSP_FILL;
      default:  rsp_state_d = RSP_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_state_q    <= REQ_IDLE;
      rsp_state_q    <= RSP_FILL;
      mem_req_addr_q <= '0;
      beat_cnt_q     <= '0;
      line_q         <= '0;
      rx_id_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      req_state_q    <= req_state_d;
      rsp_state_q    <= rsp_state_d;
      mem_req_addr_q <= mem_req_addr_d;
      beat_cnt_q     <= beat_cnt_d;
      line_q         <= line_d;
      rx_id_q        <= rx_id_d;
      err_q          <= err_d;
    end
  end

  assign mem_req_addr              = mem_req_addr_q;
  assign downstream_rxdat_pld      = line_q;
  assign downstream_rxdat_entry_id = rx_id_q;
  assign outstanding_cnt           = fifo_cnt;
  assign err_unexp_rsp             = err_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed + randomized bench for icache_refill_ctrl against a queue-based refill model.
module tb_icache_refill_ctrl;
  localparam int AW = 32, LW = 256, BW = 64, IW = 4, D = 4;

  logic          clk, rst_n;
  logic          txreq_vld, txreq_rdy;
  logic [AW-1:0] txreq_pld;
  logic [IW-1:0] txreq_id;
  logic          rxdat_vld, rxdat_rdy;
  logic [LW-1:0] rxdat_pld;
  logic [IW-1:0] rxdat_id;
  logic          mem_req_vld, mem_req_rdy;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_vld, mem_rsp_rdy;
  logic [BW-1:0] mem_rsp_data;
  logic [2:0]    outstanding_cnt;
  logic          err_unexp_rsp;

  icache_refill_ctrl #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW), .ID_W(IW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .downstream_txreq_vld(txreq_vld), .downstream_txreq_rdy(txreq_rdy),
    .downstream_txreq_pld(txreq_pld), .downstream_txreq_entry_id(txreq_id),
    .downstream_rxdat_vld(rxdat_vld), .downstream_rxdat_rdy(rxdat_rdy),
    .downstream_rxdat_pld(rxdat_pld), .downstream_rxdat_entry_id(rxdat_id),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_data(mem_rsp_data),
    .outstanding_cnt(outstanding_cnt), .err_unexp_rsp(err_unexp_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: ids waiting for a line, addresses waiting for mem_req,
  // beats of the line being assembled, and completed lines/ids awaiting delivery.
  logic [IW-1:0] id_q[$];
  logic [AW-1:0] addr_q[$];
  logic [BW-1:0] beat_buf[$];
  logic [LW-1:0] line_q[$];
  logic [IW-1:0] rid_q[$];
  logic          exp_err;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    id_q.delete(); addr_q.delete(); beat_buf.delete(); line_q.delete(); rid_q.delete();
    exp_err = 1'b0;
  endtask

  task automatic model_req(input logic [AW-1:0] a, input logic [IW-1:0] id);
    id_q.push_back(id);
    addr_q.push_back({a[AW-1:5], 5'd0});
  endtask

  task automatic model_beat(input logic [BW-1:0] d);
    if (id_q.size() == 0 && beat_buf.size() == 0) begin
      exp_err = 1'b1;
    end else begin
      beat_buf.push_back(d);
      if (beat_buf.size() == LW / BW) begin
        line_q.push_back({beat_buf[3], beat_buf[2], beat_buf[1], beat_buf[0]});
        rid_q.push_back(id_q.pop_front());
        beat_buf.delete();
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req_vld"}, mem_req_vld, 0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
    chk({tag, "_rxdat_vld"}, rxdat_vld, 0);
    chk({tag, "_rxdat_pld"}, rxdat_pld, 0);
    chk({tag, "_rxdat_id"}, rxdat_id, 0);
    chk({tag, "_outstanding"}, outstanding_cnt, 0);
    chk({tag, "_err"}, err_unexp_rsp, 0);
    chk({tag, "_mem_rsp_rdy"}, mem_rsp_rdy, 1);
    chk({tag, "_txreq_rdy"}, txreq_rdy, 1);
  endtask

  task automatic send_req(input logic [AW-1:0] a, input logic [IW-1:0] id);
    int t = 0;
    txreq_vld = 1'b1; txreq_pld = a; txreq_id = id;
    while (!txreq_rdy && t < 50) begin step(); t++; end
    chk("txreq_accept", txreq_rdy, 1);
    step();
    txreq_vld = 1'b0;
    if (t < 50) model_req(a, id);
  endtask

  task automatic accept_mem(input int stall);
    logic [AW-1:0] a0;
    int t = 0;
    while (!mem_req_vld && t < 50) begin step(); t++; end
    chk("mem_req_vld", mem_req_vld, 1);
    a0 = (addr_q.size() != 0) ? addr_q.pop_front() : '0;
    chk("mem_req_addr", mem_req_addr, a0);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("mem_req_vld_stall", mem_req_vld, 1);
      chk("mem_req_addr_stall", mem_req_addr, a0);
      chk("txreq_rdy_pend", txreq_rdy, 0);
    end
    mem_req_rdy = 1'b1;
    step();
    mem_req_rdy = 1'b0;
    chk("mem_req_vld_done", mem_req_vld, 0);
  endtask

  task automatic send_beat(input logic [BW-1:0] d);
    int t = 0;
    mem_rsp_vld = 1'b1; mem_rsp_data = d;
    while (!mem_rsp_rdy && t < 50) begin step(); t++; end
    chk("mem_rsp_rdy", mem_rsp_rdy, 1);
    step();
    mem_rsp_vld = 1'b0;
    if (t < 50) model_beat(d);
  endtask

  task automatic send_line();
    for (int b = 0; b < LW / BW; b++) send_beat({$urandom(), $urandom()});
  endtask

  task automatic recv_line(input int stall);
    logic [LW-1:0] el;
    logic [IW-1:0] ei;
    int t = 0;
    while (!rxdat_vld && t < 50) begin step(); t++; end
    chk("rxdat_vld", rxdat_vld, 1);
    el = (line_q.size() != 0) ? line_q.pop_front() : '0;
    ei = (rid_q.size() != 0) ? rid_q.pop_front() : '0;
    chk("rxdat_pld", rxdat_pld, el);
    chk("rxdat_id", rxdat_id, ei);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("rxdat_vld_hold", rxdat_vld, 1);
      chk("rxdat_pld_hold", rxdat_pld, el);
      chk("rxdat_id_hold", rxdat_id, ei);
      chk("mem_rsp_rdy_hold", mem_rsp_rdy, 0);
    end
    rxdat_rdy = 1'b1;
    step();
    rxdat_rdy = 1'b0;
    chk("rxdat_vld_done", rxdat_vld, 0);
    chk("mem_rsp_rdy_back", mem_rsp_rdy, 1);
    chk("outstanding", outstanding_cnt, id_q.size());
    chk("err_unexp", err_unexp_rsp, exp_err);
  endtask

  initial begin
    int n;
    logic [IW-1:0] ids[4];
    rst_n = 1'b0;
    txreq_vld = 1'b0; txreq_pld = '0; txreq_id = '0;
    rxdat_rdy = 1'b0; mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_data = '0;
    model_reset();
    repeat (3) step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // Single miss with fixed beats.
    send_req(32'h0000_1234, 4'd3);
    chk("single_addr", mem_req_addr, 32'h0000_1220);
    accept_mem(0);
    send_beat({8{8'h11}}); send_beat({8{8'h22}}); send_beat({8{8'h33}}); send_beat({8{8'h44}});
    chk("single_beat0", rxdat_pld[63:0], 64'h1111_1111_1111_1111);
    chk("single_beat3", rxdat_pld[255:192], 64'h4444_4444_4444_4444);
    recv_line(0);

    // mem_req backpressure.
    send_req($urandom(), 4'd5);
    accept_mem(5);
    send_line();
    recv_line(0);

    // Fill to depth, then drain in order; one line held under rxdat backpressure.
    for (int k = 0; k < D; k++) begin
      send_req($urandom(), IW'(k + 1));
      accept_mem(0);
    end
    chk("full_cnt", outstanding_cnt, D);
    chk("full_txreq_rdy", txreq_rdy, 0);
    for (int k = 0; k < D; k++) begin
      send_line();
      recv_line(k == 1 ? 10 : 0);
    end

    // Push and pop in the same cycle keep the count.
    send_req($urandom(), 4'd10);
    accept_mem(0);
    for (int b = 0; b < 3; b++) send_beat({$urandom(), $urandom()});
    chk("pushpop_before", outstanding_cnt, 1);
    mem_rsp_data = {$urandom(), $urandom()};
    mem_rsp_vld = 1'b1; txreq_vld = 1'b1; txreq_pld = $urandom(); txreq_id = 4'd11;
    chk("pushpop_txreq_rdy", txreq_rdy, 1);
    chk("pushpop_rsp_rdy", mem_rsp_rdy, 1);
    step();
    model_beat(mem_rsp_data);
    model_req(txreq_pld, txreq_id);
    mem_rsp_vld = 1'b0; txreq_vld = 1'b0;
    chk("pushpop_after", outstanding_cnt, id_q.size());
    recv_line(0);
    accept_mem(0);
    send_line();
    recv_line(0);

    // Randomized bursts of misses.
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, D);
      for (int k = 0; k < n; k++) begin
        ids[k] = IW'($urandom_range(0, 15));
        send_req($urandom(), ids[k]);
        accept_mem($urandom_range(0, 3));
      end
      chk("rand_cnt", outstanding_cnt, n);
      for (int k = 0; k < n; k++) begin
        send_line();
        recv_line($urandom_range(0, 4));
      end
    end

    // Unexpected response with nothing outstanding.
    send_beat(64'hdead_beef_0000_0001);
    chk("unexp_err", err_unexp_rsp, 1);
    chk("unexp_cnt", outstanding_cnt, 0);
    chk("unexp_rxdat_vld", rxdat_vld, 0);
    repeat (5) step();
    chk("unexp_err_sticky", err_unexp_rsp, 1);
    send_req($urandom(), 4'd9);
    accept_mem(0);
    send_line();
    recv_line(0);

    // Reset in the middle of a line.
    send_req($urandom(), 4'd6);
    accept_mem(0);
    send_beat({$urandom(), $urandom()});
    send_beat({$urandom(), $urandom()});
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    chk("post_reset_txreq_rdy", txreq_rdy, 1);
    send_req(32'h0000_ABCD, 4'd7);
    chk("post_reset_addr", mem_req_addr, 32'h0000_ABC0);
    accept_mem(0);
    send_line();
    recv_line(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
